// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Start/done handshake; the last result is held on BCD between conversions.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
  localparam longint unsigned BIN_MAX   = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("bin_to_bcd_seq: WIDTH must be in 1..16");
    end
    if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]  acc_q, acc_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Digits are adjusted independently; a digit <= 9 plus 3 never exceeds 12.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          sh_d    = BIN;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = {adj[BCD_W-2:0], sh_q[WIDTH-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = acc_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign BCD  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized bench for bin_to_bcd_seq at three WIDTH/DIGITS
// points, checked against a divide-by-ten decimal reference model.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, busy8, done8;
  logic [7:0]  bin8 = '0;
  logic [11:0] bcd8;
  logic        start4 = 1'b0, busy4, done4;
  logic [3:0]  bin4 = '0;
  logic [7:0]  bcd4;
  logic        start12 = 1'b0, busy12, done12;
  logic [11:0] bin12 = '0;
  logic [15:0] bcd12;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .BCD(bcd8)
  );
  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .BIN(bin4),
    .BUSY(busy4), .DONE(done4), .BCD(bcd4)
  );
  bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) dut12 (
    .CLK(clk), .RST(rst), .START(start12), .BIN(bin12),
    .BUSY(busy12), .DONE(done12), .BCD(bcd12)
  );

  function automatic logic [31:0] ref_bcd(input int v);
    int x = v;
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    case (w)
      4:  return done4;
      12: return done12;
      default: return done8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:  return busy4;
      12: return busy12;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [31:0] get_bcd(input int w);
    case (w)
      4:  return 32'(bcd4);
      12: return 32'(bcd12);
      default: return 32'(bcd8);
    endcase
  endfunction

  task automatic apply_stimulus(input int w, input logic s, input int v);
    case (w)
      4:  begin start4  = s; bin4  = 4'(v);  end
      12: begin start12 = s; bin12 = 12'(v); end
      default: begin start8 = s; bin8 = 8'(v); end
    endcase
  endtask

  // One full handshake: accept, watch BUSY, measure latency, check result and pulse width.
  task automatic convert(input int w, input int v, input string tag);
    int lat = 0;
    bit busy_ok = 1'b1;
    apply_stimulus(w, 1'b1, v);
    tick();
    apply_stimulus(w, 1'b0, v);
    check_output({tag, "_busy_accept"}, 32'(get_busy(w)), 32'd1);
    while (get_done(w) !== 1'b1 && lat < 4 * w + 10) begin
      if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check_output({tag, "_latency"}, 32'(lat), 32'(w));
    check_output({tag, "_bcd"}, get_bcd(w), ref_bcd(v));
    check_output({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check_output({tag, "_busy_done"}, 32'(get_busy(w)), 32'd0);
    tick();
    check_output({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
    check_output({tag, "_bcd_hold"}, get_bcd(w), ref_bcd(v));
  endtask

  initial begin
    int lat;
    bit ok;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_output("rst_busy8", 32'(busy8), 32'd0);
    check_output("rst_done8", 32'(done8), 32'd0);
    check_output("rst_bcd8", 32'(bcd8), 32'd0);
    check_output("rst_bcd4", 32'(bcd4), 32'd0);
    check_output("rst_bcd12", 32'(bcd12), 32'd0);

    convert(8, 0, "c0");
    convert(8, 255, "c255");
    convert(8, 99, "c99");
    convert(8, 100, "c100");

    // Second START and BIN churn during a conversion must be ignored.
    convert(8, 42, "c42");
    apply_stimulus(8, 1'b1, 200);
    tick();
    lat = 0;
    ok = 1'b1;
    while (done8 !== 1'b1 && lat < 30) begin
      if (bcd8 !== 12'h042) ok = 1'b0;
      apply_stimulus(8, 1'b1, int'($urandom_range(0, 255)));
      tick();
      lat++;
    end
    apply_stimulus(8, 1'b0, 0);
    check_output("ign_bcd_hold", 32'(ok), 32'd1);
    check_output("ign_latency", 32'(lat), 32'd8);
    check_output("ign_bcd", 32'(bcd8), 32'h200);
    tick();
    check_output("ign_done_pulse", 32'(done8), 32'd0);

    // Reset on the 4th SHIFT edge aborts without a DONE pulse.
    apply_stimulus(8, 1'b1, 173);
    tick();
    apply_stimulus(8, 1'b0, 173);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort_busy", 32'(busy8), 32'd0);
    check_output("abort_done", 32'(done8), 32'd0);
    check_output("abort_bcd", 32'(bcd8), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 1'b0;
    end
    check_output("abort_quiet", 32'(ok), 32'd1);
    convert(8, 173, "c173");

    // START coinciding with reset is dropped.
    rst = 1'b1;
    apply_stimulus(8, 1'b1, 55);
    tick();
    rst = 1'b0;
    apply_stimulus(8, 1'b0, 55);
    check_output("rst_start_busy", 32'(busy8), 32'd0);
    tick();
    check_output("rst_start_busy2", 32'(busy8), 32'd0);

    // START held high, BIN stepping 0..255: a result every WIDTH+1 cycles.
    apply_stimulus(8, 1'b1, 0);
    tick();
    apply_stimulus(8, 1'b1, 1);
    for (int v = 0; v < 256; v++) begin
      lat = 0;
      while (done8 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      check_output($sformatf("stream_lat_%0d", v), 32'(lat + ((v == 0) ? 0 : 1)), 32'((v == 0) ? 8 : 9));
      check_output($sformatf("stream_bcd_%0d", v), 32'(bcd8), ref_bcd(v));
      if (v == 255) begin
        apply_stimulus(8, 1'b0, 0);
        tick();
      end else begin
        tick();
        apply_stimulus(8, 1'b1, (v + 2) % 256);
      end
    end
    check_output("stream_end_busy", 32'(busy8), 32'd0);

    for (int i = 0; i < 16; i++) begin
      convert(8, int'($urandom_range(0, 255)), $sformatf("rnd8_%0d", i));
    end

    convert(4, 15, "w4_15");
    for (int i = 0; i < 6; i++) begin
      convert(4, int'($urandom_range(0, 15)), $sformatf("rnd4_%0d", i));
    end
    convert(12, 4095, "w12_4095");
    for (int i = 0; i < 6; i++) begin
      convert(12, int'($urandom_range(0, 4095)), $sformatf("rnd12_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the hex display driver. It converts a captured switch or counter value into packed decimal digits that the display block shows as 0–9 per digit. Conversions are requested with a start/done handshake, and the last result is held stable between conversions.

## Interface
Parameters:
- WIDTH, 8, binary input width; legal range 1–16.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1. A violation is an elaboration error.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset; sampled on the rising edge of CLK.
- START  input  1  conversion request; sampled only in IDLE.
- BIN  input  WIDTH  unsigned binary value; captured on the accepting edge.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when BCD updates.
- BCD  output  4*DIGITS  packed result; digit 0 (units) is in BCD[3:0], digit i is in BCD[4i+3:4i].

## Operation
- States are IDLE and SHIFT. Internal registers:
  - shift register sh, WIDTH bits
  - scratch register acc, 4*DIGITS bits
  - bit counter cnt, ceil(log2(WIDTH+1)) bits
- Reset (RST=1 at an edge) has priority over everything. It sets:
  - state to IDLE
  - BUSY=0, DONE=0, BCD=0
  - acc=0, sh=0, cnt=0
- IDLE:
  - DONE is driven 0 unless set on the previous edge (see SHIFT).
  - If START=1: sh<=BIN, acc<=0, cnt<=0, BUSY<=1, state<=SHIFT.
  - If START=0: all registers hold.
- SHIFT, each edge:
  - Form adj: every 4-bit digit of acc that is ≥5 gets +3; digits are adjusted independently, with no carry between digits.
  - Then shift {adj, sh} left by one: acc<={adj[4*DIGITS-2:0], sh[WIDTH-1]}, sh<={sh[WIDTH-2:0],1'b0}.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, this edge performs the final shift and also:
    - BCD<= the shifted acc value
    - DONE<=1, BUSY<=0, state<=IDLE
- While in SHIFT:
  - START is ignored.
  - Changes on BIN are ignored.
  - BCD holds the previous result.
- DONE is high for exactly one cycle per completed conversion. An aborted conversion never produces DONE.
- Digit invariant: every acc digit is ≤9 after each shift. adj digits are ≤12 and therefore fit in 4 bits.

## Timing
- An accepting edge k has START=1 in IDLE. BUSY is high from after edge k until after edge k+WIDTH.
- Latency: BCD and DONE are valid after edge k+WIDTH, i.e. WIDTH cycles after acceptance.
- The DONE cycle is an IDLE cycle. START=1 during it is accepted at edge k+WIDTH+1.
- Maximum throughput is one conversion per WIDTH+1 cycles. With START held high continuously, DONE pulses every WIDTH+1 cycles.
- Reset mid-conversion (RST=1 at any SHIFT edge):
  - Next cycle: BUSY=0, DONE=0, BCD=0.
  - A START asserted in the same cycle as RST is dropped.
- WIDTH=1: the single SHIFT edge is also the completion edge, so latency is 1 cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then BIN=8'd0 with a 1-cycle START -> BUSY high for 8 cycles, then DONE pulse; BCD=12'h000.
- BIN=8'd255 with START -> after 8 cycles BCD=12'h255 and DONE=1 for exactly 1 cycle. Repeat with 99 -> 12'h099 and 100 -> 12'h100.
- After a result of 12'h042, set BIN=200 and assert START again during BUSY, while also changing BIN every cycle -> second START ignored; final BCD=12'h200. BCD reads 12'h042 until the DONE edge.
- Start a conversion of 8'd173 and assert RST at the 4th SHIFT edge -> BUSY=0, BCD=0, no DONE pulse. A new START with 8'd173 then gives 12'h173 after 8 cycles.
- START held high with BIN stepping through 0..255 -> DONE every 9 cycles. Every BCD result must match a decimal reference model; all 256 values are covered.
- Parameter sweep WIDTH=4/DIGITS=2 and WIDTH=12/DIGITS=4:
  - 4'd15 -> 8'h15 with latency 4
  - 12'd4095 -> 16'h4095 with latency 12
